// File: rtl/upload_pkg.sv
// Shared types and constants for the upload packetizer: frame state encoding,
// default sync bytes and length-field geometry.
package upload_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR0,
    ST_HDR1,
    ST_SRC,
    ST_LENH,
    ST_LENL,
    ST_PAY,
    ST_CSUM
  } frame_state_e;

  localparam logic [7:0] SYNC0_DEF = 8'hAA;
  localparam logic [7:0] SYNC1_DEF = 8'h55;
  localparam int         HDR_LEN   = 5;
  localparam int         LEN_W     = 16;

  // Bytes on the wire for one frame: header, payload, trailing checksum.
  function automatic int frame_bytes(input int len);
    return HDR_LEN + len + 1;
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload byte buffer: one write port, one synchronous read port.
// Written as a plain memory array so it maps onto block RAM.
module pkt_buf_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/upload_packetizer.sv
// Frames the merged upload byte stream into SYNC0 SYNC1 src len_hi len_lo
// payload.. checksum packets for the host link, buffering one packet at a time.
module upload_packetizer
  import upload_pkg::*;
#(
  parameter int         MAX_LEN        = 256,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SYNC0          = SYNC0_DEF,
  parameter logic [7:0] SYNC1          = SYNC1_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_req,
  input  logic [7:0] in_data,
  input  logic [7:0] in_source,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  frame_state_e     state_q, state_d;
  logic             rdy_en_q;
  logic [LEN_W-1:0] len_q, len_d, len_n;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       src_q, src_d, src_n;
  logic [7:0]       csum_q, csum_d, csum_n;
  logic [TW-1:0]    idle_q, idle_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sof_q, sof_d, eof_q, eof_d;

  logic             acc, go_hdr, src_mismatch, hs;
  logic [7:0]       ram_rdata;

  assign hs           = out_valid_q && out_ready;
  assign src_mismatch = in_valid && (in_source != src_q);

  // Read address is the next pointer, so the RAM output already holds the
  // byte the output register will need on the following handshake.
  pkt_buf_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (acc),
    .waddr_i ((state_q == ST_IDLE) ? '0 : len_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    in_ready    = 1'b0;
    acc         = 1'b0;
    go_hdr      = 1'b0;
    len_n       = len_q;
    csum_n      = csum_q;
    src_n       = src_q;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = rdy_en_q;
        acc      = in_valid && rdy_en_q;
        if (acc) begin
          len_n  = LEN_W'(1);
          csum_n = in_data;
          src_n  = in_source;
          if (in_req) state_d = ST_COLLECT;
          else        go_hdr  = 1'b1;
        end
      end
      ST_COLLECT: begin
        // A byte from another source is refused and left for the next packet.
        in_ready = !src_mismatch;
        acc      = in_valid && !src_mismatch;
        if (acc) begin
          len_n  = len_q + 1'b1;
          csum_n = csum_q + in_data;
          idle_d = '0;
          if (!in_req || len_n == LEN_W'(MAX_LEN)) go_hdr = 1'b1;
        end else if (src_mismatch || idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
          go_hdr = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_HDR0: if (hs) begin
        state_d    = ST_HDR1;
        out_data_d = SYNC1;
        sof_d      = 1'b0;
      end
      ST_HDR1: if (hs) begin
        state_d    = ST_SRC;
        out_data_d = src_q;
      end
      ST_SRC: if (hs) begin
        state_d    = ST_LENH;
        out_data_d = len_q[15:8];
      end
      ST_LENH: if (hs) begin
        state_d    = ST_LENL;
        out_data_d = len_q[7:0];
      end
      ST_LENL: if (hs) begin
        state_d    = ST_PAY;
        out_data_d = ram_rdata;
        rd_ptr_d   = LEN_W'(1);
      end
      ST_PAY: if (hs) begin
        if (rd_ptr_q == len_q) begin
          state_d    = ST_CSUM;
          out_data_d = csum_q;
          eof_d      = 1'b1;
          rd_ptr_d   = '0;
        end else begin
          out_data_d = ram_rdata;
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end
      ST_CSUM: if (hs) begin
        state_d     = ST_IDLE;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        eof_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    len_d  = len_n;
    src_d  = src_n;
    csum_d = csum_n;

    // Payload sum is complete here; fold in the header fields once.
    if (go_hdr) begin
      state_d     = ST_HDR0;
      idle_d      = '0;
      csum_d      = csum_n + src_n + len_n[15:8] + len_n[7:0];
      out_data_d  = SYNC0;
      out_valid_d = 1'b1;
      sof_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      src_q       <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      src_q       <= src_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
